// File: rtl/buffer_drain_pkg.sv
// buffer_drain_pkg: drain FSM state encodings and default word width (`inputWidth) for buffer_drain.
`ifndef inputWidth
`define inputWidth 32
`endif
package buffer_drain_pkg;
  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_LOCK  = 2'd1,
    DRAIN_CLEAR = 2'd2,
    DRAIN_SEND  = 2'd3
  } drain_state_t;
endpackage

// File: rtl/buffer_drain_rr_pick.sv
// rr_pick: first set bit of req at or after start, wrapping modulo N.
module rr_pick
  import buffer_drain_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          hit,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  // scan offsets from far to near so the closest hit after start wins
  always_comb begin
    hit = |req;
    idx = '0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(start) + k) % N);
      if (req[j]) idx = j;
    end
  end
endmodule

// File: rtl/buffer_drain.sv
// buffer_drain: freezes, copies and clears one full holding buffer at a time onto a valid/ready stream.
// Define DRAIN_FIXED_PRIO_EN to select the lowest full index instead of round-robin.
`ifndef inputWidth
`define inputWidth 32
`endif
module buffer_drain
  import buffer_drain_pkg::*;
#(
  parameter int NUM_BUF = 4,
  parameter int DATA_W  = `inputWidth,
  parameter int IDX_W   = $clog2(NUM_BUF)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_BUF-1:0]        full,
  input  logic [NUM_BUF*DATA_W-1:0] buf_data,
  output logic [NUM_BUF-1:0]        rd,
  output logic [NUM_BUF-1:0]        clr,
  output logic [DATA_W-1:0]         m_data,
  output logic [IDX_W-1:0]          m_idx,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      busy
);
  drain_state_t state, nx_state;
  logic [IDX_W-1:0] sel, nx_sel, ptr, nx_ptr, start, pick;
  logic [NUM_BUF-1:0] nx_rd, nx_clr;
  logic [DATA_W-1:0] nx_data;
  logic [IDX_W-1:0] nx_idx;
  logic nx_valid, hit;
`ifdef DRAIN_FIXED_PRIO_EN
  assign start = '0;
`else
  assign start = ptr;
`endif
  rr_pick #(.N(NUM_BUF), .IW(IDX_W)) u_pick (
    .req  (full),
    .start(start),
    .hit  (hit),
    .idx  (pick)
  );
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= DRAIN_IDLE;
      sel     <= '0;
      ptr     <= '0;
      rd      <= '0;
      clr     <= '0;
      m_data  <= '0;
      m_idx   <= '0;
      m_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= nx_state;
      sel     <= nx_sel;
      ptr     <= nx_ptr;
      rd      <= nx_rd;
      clr     <= nx_clr;
      m_data  <= nx_data;
      m_idx   <= nx_idx;
      m_valid <= nx_valid;
      busy    <= nx_state != DRAIN_IDLE;
    end
  end
  always_comb begin
    nx_state = state;
    nx_sel   = sel;
    nx_ptr   = ptr;
    nx_rd    = rd;
    nx_clr   = clr;
    nx_data  = m_data;
    nx_idx   = m_idx;
    nx_valid = m_valid;
    case (state)
      DRAIN_IDLE: if (hit) begin
        nx_rd    = NUM_BUF'(1) << pick;
        nx_sel   = pick;
        nx_state = DRAIN_LOCK;
      end
      // a buffer emptied behind our back is abandoned without clearing
      DRAIN_LOCK: if (!full[sel]) begin
        nx_rd    = '0;
        nx_state = DRAIN_IDLE;
      end else begin
        nx_data  = buf_data[sel*DATA_W +: DATA_W];
        nx_idx   = sel;
        nx_clr   = rd;
        nx_state = DRAIN_CLEAR;
      end
      DRAIN_CLEAR: begin
        nx_clr   = '0;
        nx_rd    = '0;
        nx_valid = 1'b1;
`ifndef DRAIN_FIXED_PRIO_EN
        nx_ptr   = (sel == IDX_W'(NUM_BUF - 1)) ? '0 : sel + 1'b1;
`endif
        nx_state = DRAIN_SEND;
      end
      DRAIN_SEND: if (m_ready) begin
        nx_valid = 1'b0;
        nx_state = DRAIN_IDLE;
      end
      default: nx_state = DRAIN_IDLE;
    endcase
  end
endmodule
